// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// Holds the mode enum, digit count and anode helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_e;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    function automatic logic [3:0] anode_of(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The level flips only after DB_CNT consecutive differing samples.
module debouncer #(
    parameter int DB_CNT = 1_000_000,
    parameter int DB_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CNT - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // a sample equal to the level keeps the count at zero
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM, counter strobes and display scan control.
// Buttons and switches are synchronized and debounced on-chip.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CNT = 1_000_000,
    parameter int DB_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_scan,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       clr,
    output logic [1:0] digit_sel,
    output logic [3:0] anode
);

    logic pause_lvl, reset_lvl, adj_lvl, sel_lvl;

    debouncer #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_pause (
        .clk(clk), .rst_n(rst_n), .din(btn_pause), .level(pause_lvl)
    );
    debouncer #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_reset (
        .clk(clk), .rst_n(rst_n), .din(btn_reset), .level(reset_lvl)
    );
    debouncer #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_adj (
        .clk(clk), .rst_n(rst_n), .din(sw_adj), .level(adj_lvl)
    );
    debouncer #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .din(sw_sel), .level(sel_lvl)
    );

    state_e     state_q,     state_d;
    state_e     saved_q,     saved_d;
    logic       pause_prv_q, pause_prv_d;
    logic       reset_prv_q, reset_prv_d;
    logic       inc_sec_q,   inc_sec_d;
    logic       inc_min_q,   inc_min_d;
    logic       clr_q,       clr_d;
    logic [1:0] digit_sel_q, digit_sel_d;
    logic [3:0] anode_q,     anode_d;
    logic       blink_q,     blink_d;

    logic pause_evt, reset_evt, blank;

    always_comb begin
        pause_prv_d = pause_lvl;
        reset_prv_d = reset_lvl;
        pause_evt   = pause_lvl & ~pause_prv_q;
        reset_evt   = reset_lvl & ~reset_prv_q;

        state_d = state_q;
        saved_d = saved_q;
        // adjust switch outranks a same-cycle pause event
        unique case (state_q)
            RUN: begin
                if (adj_lvl) begin
                    state_d = ADJUST;
                    saved_d = RUN;
                end else if (pause_evt) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (adj_lvl) begin
                    state_d = ADJUST;
                    saved_d = PAUSED;
                end else if (pause_evt) begin
                    state_d = RUN;
                end
            end
            ADJUST: begin
                if (!adj_lvl) state_d = saved_q;
            end
            default: state_d = RUN;
        endcase

        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        unique case (state_q)
            RUN: inc_sec_d = tick_1hz;
            ADJUST: begin
                inc_sec_d = tick_2hz & sel_lvl;
                inc_min_d = tick_2hz & ~sel_lvl;
            end
            default: ;
        endcase
        if (reset_evt) begin
            inc_sec_d = 1'b0;
            inc_min_d = 1'b0;
        end
        clr_d = reset_evt;

        digit_sel_d = digit_sel_q;
        if (tick_scan) begin
            if (digit_sel_q == 2'(NUM_DIGITS - 1)) digit_sel_d = 2'd0;
            else digit_sel_d = digit_sel_q + 2'd1;
        end
        blink_d = blink_q ^ tick_2hz;

        // digit_sel[1] picks the minutes pair; sw_sel=1 selects seconds
        blank = (state_d == ADJUST) && blink_d
              && (digit_sel_d[1] != sel_lvl);
        anode_d = blank ? ANODE_OFF : anode_of(digit_sel_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            pause_prv_q <= 1'b0;
            reset_prv_q <= 1'b0;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            clr_q       <= 1'b0;
            digit_sel_q <= 2'd0;
            anode_q     <= 4'b1110;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            pause_prv_q <= pause_prv_d;
            reset_prv_q <= reset_prv_d;
            inc_sec_q   <= inc_sec_d;
            inc_min_q   <= inc_min_d;
            clr_q       <= clr_d;
            digit_sel_q <= digit_sel_d;
            anode_q     <= anode_d;
            blink_q     <= blink_d;
        end
    end

    assign inc_sec   = inc_sec_q;
    assign inc_min   = inc_min_q;
    assign clr       = clr_q;
    assign digit_sel = digit_sel_q;
    assign anode     = anode_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
// Each task drives one scenario and checks outputs inline.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       tick_scan = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic       inc_sec, inc_min, clr;
    logic [1:0] digit_sel;
    logic [3:0] anode;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_CNT(4), .DB_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_scan(tick_scan),
        .btn_pause(btn_pause), .btn_reset(btn_reset),
        .sw_adj(sw_adj), .sw_sel(sw_sel),
        .inc_sec(inc_sec), .inc_min(inc_min), .clr(clr),
        .digit_sel(digit_sel), .anode(anode)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (anode !== 4'b1110) begin
            fails++;
            $display("FAIL reset_anode got %b want 1110", anode);
        end
        tests++;
        if (digit_sel !== 2'd0) begin
            fails++;
            $display("FAIL reset_digit got %0d want 0", digit_sel);
        end
        tests++;
        if ({inc_sec, inc_min, clr} !== 3'b000) begin
            fails++;
            $display("FAIL reset_strobes got %b want 000",
                     {inc_sec, inc_min, clr});
        end
        step(2);
        rst_n = 1'b1;
        step(3);
        tests++;
        if (dut.state_q !== RUN) begin
            fails++;
            $display("FAIL reset_state got %0d want %0d",
                     dut.state_q, RUN);
        end
    endtask

    task automatic test_run_ticks();
        int seen;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            if (inc_sec === 1'b1) seen++;
            tests++;
            if (inc_sec !== 1'b1 || inc_min !== 1'b0) begin
                fails++;
                $display("FAIL run_tick%0d got sec=%b min=%b want 1 0",
                         i, inc_sec, inc_min);
            end
            step(1);
            if (inc_sec === 1'b1) seen++;
            step(1);
            if (inc_sec === 1'b1) seen++;
        end
        tests++;
        if (seen != 3) begin
            fails++;
            $display("FAIL run_count got %0d want 3", seen);
        end
    endtask

    task automatic test_pause();
        btn_pause = 1'b1;
        step(3);
        btn_pause = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== RUN) begin
            fails++;
            $display("FAIL short_press_state got %0d want %0d",
                     dut.state_q, RUN);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b1) begin
            fails++;
            $display("FAIL short_press_tick got %b want 1", inc_sec);
        end
        btn_pause = 1'b1;
        step(10);
        btn_pause = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== PAUSED) begin
            fails++;
            $display("FAIL long_press_state got %0d want %0d",
                     dut.state_q, PAUSED);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b0 || inc_min !== 1'b0) begin
            fails++;
            $display("FAIL paused_tick got sec=%b min=%b want 0 0",
                     inc_sec, inc_min);
        end
    endtask

    task automatic test_adjust_min();
        sw_sel = 1'b0;
        sw_adj = 1'b1;
        step(8);
        tests++;
        if (dut.state_q !== ADJUST) begin
            fails++;
            $display("FAIL adj_enter got %0d want %0d",
                     dut.state_q, ADJUST);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b0 || inc_min !== 1'b0) begin
            fails++;
            $display("FAIL adj_1hz got sec=%b min=%b want 0 0",
                     inc_sec, inc_min);
        end
        for (int i = 0; i < 2; i++) begin
            step(2);
            tick_2hz = 1'b1;
            step(1);
            tick_2hz = 1'b0;
            tests++;
            if (inc_min !== 1'b1 || inc_sec !== 1'b0) begin
                fails++;
                $display("FAIL adj_2hz%0d got min=%b sec=%b want 1 0",
                         i, inc_min, inc_sec);
            end
        end
        sw_adj = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== PAUSED) begin
            fails++;
            $display("FAIL adj_exit got %0d want %0d",
                     dut.state_q, PAUSED);
        end
        btn_pause = 1'b1;
        step(6);
        btn_pause = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== RUN) begin
            fails++;
            $display("FAIL resume got %0d want %0d",
                     dut.state_q, RUN);
        end
    endtask

    task automatic test_clr();
        btn_reset = 1'b1;
        step(6);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (clr !== 1'b1 || inc_sec !== 1'b0 || inc_min !== 1'b0) begin
            fails++;
            $display("FAIL clr_cycle got clr=%b sec=%b min=%b want 1 0 0",
                     clr, inc_sec, inc_min);
        end
        step(1);
        tests++;
        if (clr !== 1'b0) begin
            fails++;
            $display("FAIL clr_width got %b want 0", clr);
        end
        btn_reset = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== RUN) begin
            fails++;
            $display("FAIL clr_state got %0d want %0d",
                     dut.state_q, RUN);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b1 || clr !== 1'b0) begin
            fails++;
            $display("FAIL clr_after got sec=%b clr=%b want 1 0",
                     inc_sec, clr);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_d [5];
        logic [3:0] exp_a [5];
        logic [3:0] exp_b [4];
        exp_d = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_a = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        for (int i = 0; i < 5; i++) begin
            tick_scan = 1'b1;
            step(1);
            tick_scan = 1'b0;
            tests++;
            if (digit_sel !== exp_d[i] || anode !== exp_a[i]) begin
                fails++;
                $display("FAIL scan%0d got d=%0d a=%b want d=%0d a=%b",
                         i, digit_sel, anode, exp_d[i], exp_a[i]);
            end
            step(1);
        end
        sw_sel = 1'b1;
        sw_adj = 1'b1;
        step(8);
        tick_2hz = 1'b1;
        step(1);
        tick_2hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b1 || inc_min !== 1'b0) begin
            fails++;
            $display("FAIL adj_sec got sec=%b min=%b want 1 0",
                     inc_sec, inc_min);
        end
        step(1);
        tests++;
        if (anode !== 4'b1111) begin
            fails++;
            $display("FAIL blink_d1 got %b want 1111", anode);
        end
        exp_b = '{4'b1011, 4'b0111, 4'b1111, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            tick_scan = 1'b1;
            step(1);
            tick_scan = 1'b0;
            tests++;
            if (anode !== exp_b[i]) begin
                fails++;
                $display("FAIL blink_scan%0d got %b want %b",
                         i, anode, exp_b[i]);
            end
        end
        sw_adj = 1'b0;
        step(8);
        tests++;
        if (dut.state_q !== RUN || anode !== 4'b1101) begin
            fails++;
            $display("FAIL blink_exit got st=%0d a=%b want %0d 1101",
                     dut.state_q, anode, RUN);
        end
    endtask

    task automatic test_reset_mid_debounce();
        tick_scan = 1'b1;
        step(1);
        tick_scan = 1'b0;
        btn_pause = 1'b1;
        step(4);
        rst_n = 1'b0;
        btn_pause = 1'b0;
        #1;
        tests++;
        if (anode !== 4'b1110 || digit_sel !== 2'd0) begin
            fails++;
            $display("FAIL midrst_disp got d=%0d a=%b want 0 1110",
                     digit_sel, anode);
        end
        tests++;
        if ({inc_sec, inc_min, clr} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_strobes got %b want 000",
                     {inc_sec, inc_min, clr});
        end
        step(2);
        rst_n = 1'b1;
        step(10);
        tests++;
        if (dut.state_q !== RUN) begin
            fails++;
            $display("FAIL midrst_state got %0d want %0d",
                     dut.state_q, RUN);
        end
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        tests++;
        if (inc_sec !== 1'b1) begin
            fails++;
            $display("FAIL midrst_tick got %b want 1", inc_sec);
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_pause();
        test_adjust_min();
        test_clr();
        test_scan();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
